// File: rtl/pma_region_table_pkg.sv
// pma_pkg: shared types and constants for the physical-memory-attribute table.
//   pma_attr_t     - attribute vector {nonidem, cached, exec}
//   pma_entry_t    - one table entry {base, length, attr, lock} at the full
//                    64-bit core address width
//   PMA_FIELD_*    - config-port field encodings
//   PMA_ATTR_MISS  - attributes reported for an address no entry covers
package pma_pkg;

    localparam int unsigned PMA_ADDR_W = 64;

    typedef struct packed {
        logic nonidem;
        logic cached;
        logic exec;
    } pma_attr_t;

    typedef struct packed {
        logic [PMA_ADDR_W-1:0] base;
        logic [PMA_ADDR_W-1:0] length;
        pma_attr_t             attr;
        logic                  lock;
    } pma_entry_t;

    localparam logic [1:0] PMA_FIELD_BASE   = 2'd0;
    localparam logic [1:0] PMA_FIELD_LENGTH = 2'd1;
    localparam logic [1:0] PMA_FIELD_ATTR   = 2'd2;
    localparam logic [1:0] PMA_FIELD_RSVD   = 2'd3;

    // Unmapped space is treated as I/O: not executable, not cacheable,
    // side effects possible.
    localparam pma_attr_t PMA_ATTR_MISS = '{nonidem: 1'b1, cached: 1'b0, exec: 1'b0};

endpackage

// File: rtl/pma_range_match.sv
// pma_range_match: combinational comparator for one table entry.
//   base   - first address of the region
//   length - region size in bytes; zero disables the entry
//   addr   - address being classified
//   match  - high when base <= addr < base + length and length != 0
// The end address is formed one bit wider than the address so that a region
// reaching the very top of the address space does not wrap.
module pma_range_match #(
    parameter int unsigned AddrWidth = 64
) (
    input  logic [AddrWidth-1:0] base,
    input  logic [AddrWidth-1:0] length,
    input  logic [AddrWidth-1:0] addr,
    output logic                 match
);

    logic [AddrWidth:0] end_s;

    // Range comparison against the widened end address.
    always_comb begin
        end_s = {1'b0, base} + {1'b0, length};
        match = (length != '0) && (addr >= base) && ({1'b0, addr} < end_s);
    end

endmodule

// File: rtl/pma_region_table.sv
// pma_region_table: runtime-programmable physical-memory-attribute table.
//   clk_i / rst_ni        - clock, asynchronous active-low reset
//   lookup_valid_i/addr_i - one classification request per cycle
//   lookup_*_o            - registered result, valid the cycle after the request
//   cfg_we_i/idx_i/field_i/wdata_i - CSR-style entry write port
//   cfg_err_o             - one-cycle pulse for each rejected write
// The lowest-indexed matching entry wins. A write and a lookup in the same
// cycle see the table as it was before the write.
module pma_region_table
    import pma_pkg::*;
#(
    parameter int unsigned NrRegions = 8,
    parameter int unsigned AddrWidth = 64,
    parameter logic [NrRegions*AddrWidth-1:0] RstBase   = '0,
    parameter logic [NrRegions*AddrWidth-1:0] RstLength = '0,
    parameter logic [NrRegions*3-1:0]         RstAttr   = '0,
    parameter logic [NrRegions-1:0]           RstLock   = '0,
    localparam int unsigned IdxW = (NrRegions > 1) ? $clog2(NrRegions) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 lookup_valid_i,
    input  logic [AddrWidth-1:0] lookup_addr_i,
    output logic                 lookup_valid_o,
    output logic                 lookup_hit_o,
    output logic [IdxW-1:0]      lookup_idx_o,
    output logic                 lookup_exec_o,
    output logic                 lookup_cached_o,
    output logic                 lookup_nonidem_o,
    input  logic                 cfg_we_i,
    input  logic [IdxW-1:0]      cfg_idx_i,
    input  logic [1:0]           cfg_field_i,
    input  logic [AddrWidth-1:0] cfg_wdata_i,
    output logic                 cfg_err_o
);

    logic [AddrWidth-1:0] base_r   [NrRegions];
    logic [AddrWidth-1:0] length_r [NrRegions];
    pma_attr_t            attr_r   [NrRegions];
    logic [NrRegions-1:0] lock_r;

    logic [NrRegions-1:0] match_s;
    logic                 hit_s;
    logic [IdxW-1:0]      idx_s;
    pma_attr_t            attr_s;

    logic                 idx_ok_s;
    logic                 sel_lock_s;
    logic                 reject_s;
    logic                 wr_en_s;

    for (genvar g = 0; g < NrRegions; g++) begin : g_match
        pma_range_match #(
            .AddrWidth (AddrWidth)
        ) u_match (
            .base   (base_r[g]),
            .length (length_r[g]),
            .addr   (lookup_addr_i),
            .match  (match_s[g])
        );
    end

    // Priority encoder: scanning downwards lets the lowest matching index overwrite.
    always_comb begin
        hit_s  = 1'b0;
        idx_s  = '0;
        attr_s = PMA_ATTR_MISS;
        for (int i = int'(NrRegions) - 1; i >= 0; i--) begin
            if (match_s[i]) begin
                hit_s  = 1'b1;
                idx_s  = IdxW'(i);
                attr_s = attr_r[i];
            end else begin
                hit_s  = hit_s;
            end
        end
    end

    // Config write decode: out-of-range index, reserved field or locked entry reject.
    always_comb begin
        idx_ok_s   = (32'(cfg_idx_i) < 32'(NrRegions));
        sel_lock_s = 1'b0;
        for (int i = 0; i < int'(NrRegions); i++) begin
            sel_lock_s = sel_lock_s | (lock_r[i] & (cfg_idx_i == IdxW'(i)));
        end
        reject_s = !idx_ok_s || (cfg_field_i == PMA_FIELD_RSVD) || sel_lock_s;
        wr_en_s  = cfg_we_i && !reject_s;
    end

    // Table storage: reset image load and accepted config writes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NrRegions); i++) begin
                base_r[i]   <= RstBase[i*AddrWidth +: AddrWidth];
                length_r[i] <= RstLength[i*AddrWidth +: AddrWidth];
                attr_r[i]   <= pma_attr_t'(RstAttr[i*3 +: 3]);
                lock_r[i]   <= RstLock[i];
            end
        end else begin
            for (int i = 0; i < int'(NrRegions); i++) begin
                if (wr_en_s && (cfg_idx_i == IdxW'(i))) begin
                    case (cfg_field_i)
                        PMA_FIELD_BASE:   base_r[i]   <= cfg_wdata_i;
                        PMA_FIELD_LENGTH: length_r[i] <= cfg_wdata_i;
                        PMA_FIELD_ATTR: begin
                            attr_r[i] <= pma_attr_t'(cfg_wdata_i[2:0]);
                            lock_r[i] <= lock_r[i] | cfg_wdata_i[3];
                        end
                        default: base_r[i] <= base_r[i];
                    endcase
                end
            end
        end
    end

    // Lookup result register; fields hold while no request is presented.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lookup_valid_o   <= 1'b0;
            lookup_hit_o     <= 1'b0;
            lookup_idx_o     <= '0;
            lookup_exec_o    <= 1'b0;
            lookup_cached_o  <= 1'b0;
            lookup_nonidem_o <= 1'b0;
        end else if (lookup_valid_i) begin
            lookup_valid_o   <= 1'b1;
            lookup_hit_o     <= hit_s;
            lookup_idx_o     <= idx_s;
            lookup_exec_o    <= attr_s.exec;
            lookup_cached_o  <= attr_s.cached;
            lookup_nonidem_o <= attr_s.nonidem;
        end else begin
            lookup_valid_o   <= 1'b0;
        end
    end

    // Write-reject pulse, one cycle per rejected write.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cfg_err_o <= 1'b0;
        end else begin
            cfg_err_o <= cfg_we_i && reject_s;
        end
    end

endmodule

// File: tb/tb_pma_region_table.sv
// Directed scoreboard bench for pma_region_table (6 entries, 64-bit addresses).
module tb_pma_region_table;

    localparam int unsigned NR = 6;
    localparam int unsigned AW = 64;

    logic          clk = 1'b0;
    logic          rst_ni;
    logic          lookup_valid;
    logic [AW-1:0] lookup_addr;
    logic          lookup_valid_o;
    logic          lookup_hit_o;
    logic [2:0]    lookup_idx_o;
    logic          lookup_exec_o;
    logic          lookup_cached_o;
    logic          lookup_nonidem_o;
    logic          cfg_we;
    logic [2:0]    cfg_idx;
    logic [1:0]    cfg_field;
    logic [AW-1:0] cfg_wdata;
    logic          cfg_err_o;

    typedef struct {
        logic       hit;
        logic [2:0] idx;
        logic       exec;
        logic       cached;
        logic       nonidem;
    } exp_t;

    exp_t sb [$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    pma_region_table #(
        .NrRegions (NR),
        .AddrWidth (AW),
        .RstBase   ({320'h0, 64'h0000_0000_8000_0000}),
        .RstLength ({320'h0, 64'h0000_0000_4000_0000}),
        .RstAttr   ({15'b0, 3'b011}),
        .RstLock   (6'b0)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .lookup_valid_i   (lookup_valid),
        .lookup_addr_i    (lookup_addr),
        .lookup_valid_o   (lookup_valid_o),
        .lookup_hit_o     (lookup_hit_o),
        .lookup_idx_o     (lookup_idx_o),
        .lookup_exec_o    (lookup_exec_o),
        .lookup_cached_o  (lookup_cached_o),
        .lookup_nonidem_o (lookup_nonidem_o),
        .cfg_we_i         (cfg_we),
        .cfg_idx_i        (cfg_idx),
        .cfg_field_i      (cfg_field),
        .cfg_wdata_i      (cfg_wdata),
        .cfg_err_o        (cfg_err_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic lookup(input logic [63:0] a, input logic h, input logic [2:0] i,
                          input logic e, input logic c, input logic n);
        exp_t x;
        x.hit = h; x.idx = i; x.exec = e; x.cached = c; x.nonidem = n;
        lookup_valid = 1'b1;
        lookup_addr  = a;
        sb.push_back(x);
    endtask

    // Advance one clock, sample 1 time unit after the edge, retire scoreboard.
    task automatic tick();
        exp_t x;
        @(posedge clk);
        #1;
        if (lookup_valid_o === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", 64'(lookup_valid_o), 64'd0);
            end else begin
                x = sb.pop_front();
                chk("hit",     64'(lookup_hit_o),     64'(x.hit));
                chk("idx",     64'(lookup_idx_o),     64'(x.idx));
                chk("exec",    64'(lookup_exec_o),    64'(x.exec));
                chk("cached",  64'(lookup_cached_o),  64'(x.cached));
                chk("nonidem", 64'(lookup_nonidem_o), 64'(x.nonidem));
            end
        end else if (sb.size() != 0) begin
            void'(sb.pop_front());
            chk("missing_valid", 64'(lookup_valid_o), 64'd1);
        end
        lookup_valid = 1'b0;
        cfg_we       = 1'b0;
    endtask

    task automatic set_wr(input logic [2:0] i, input logic [1:0] f, input logic [63:0] d);
        cfg_we    = 1'b1;
        cfg_idx   = i;
        cfg_field = f;
        cfg_wdata = d;
    endtask

    task automatic wr(input logic [2:0] i, input logic [1:0] f, input logic [63:0] d,
                      input logic exp_err);
        set_wr(i, f, d);
        tick();
        chk("cfg_err", 64'(cfg_err_o), 64'(exp_err));
    endtask

    initial begin
        rst_ni       = 1'b0;
        lookup_valid = 1'b0;
        lookup_addr  = '0;
        cfg_we       = 1'b0;
        cfg_idx      = '0;
        cfg_field    = '0;
        cfg_wdata    = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid",   64'(lookup_valid_o),   64'd0);
        chk("rst_hit",     64'(lookup_hit_o),     64'd0);
        chk("rst_idx",     64'(lookup_idx_o),     64'd0);
        chk("rst_nonidem", 64'(lookup_nonidem_o), 64'd0);
        chk("rst_err",     64'(cfg_err_o),        64'd0);
        rst_ni = 1'b1;

        // Reset image and its boundaries
        lookup(64'h8000_1000, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0); tick();
        lookup(64'hBFFF_FFFF, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0); tick();
        lookup(64'hC000_0000, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1); tick();
        lookup(64'h7FFF_FFFF, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1); tick();

        // Overlapping regions: entry1 exec, entry3 nonidem
        wr(3'd1, 2'd0, 64'h1_0000, 1'b0);
        wr(3'd1, 2'd1, 64'h1_0000, 1'b0);
        wr(3'd1, 2'd2, 64'h1, 1'b0);
        wr(3'd3, 2'd0, 64'h0, 1'b0);
        wr(3'd3, 2'd1, 64'h10_0000, 1'b0);
        wr(3'd3, 2'd2, 64'h4, 1'b0);
        lookup(64'h1_8000, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0); tick();
        tick();
        chk("hold_valid", 64'(lookup_valid_o), 64'd0);
        chk("hold_hit",   64'(lookup_hit_o),   64'd1);
        chk("hold_idx",   64'(lookup_idx_o),   64'd1);
        chk("hold_exec",  64'(lookup_exec_o),  64'd1);
        lookup(64'h1_0000, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0); tick();
        lookup(64'h2_0000, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1); tick();
        lookup(64'h0_FFFF, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1); tick();

        // Lock entry 2 (exec), then every write to it is rejected
        wr(3'd2, 2'd2, 64'h9, 1'b0);
        wr(3'd2, 2'd1, 64'h1000, 1'b1);
        tick();
        chk("err_single_pulse", 64'(cfg_err_o), 64'd0);
        wr(3'd2, 2'd0, 64'h5000, 1'b1);
        wr(3'd2, 2'd2, 64'h0, 1'b1);
        tick();
        chk("err_clear", 64'(cfg_err_o), 64'd0);
        lookup(64'h0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1); tick();

        // Out-of-range index and reserved field back to back
        wr(3'd6, 2'd0, 64'h1234, 1'b1);
        wr(3'd0, 2'd3, 64'h0, 1'b1);
        wr(3'd7, 2'd1, 64'h1, 1'b1);
        tick();
        chk("err_after_rejects", 64'(cfg_err_o), 64'd0);
        lookup(64'h8000_0000, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0); tick();

        // Back-to-back writes to one entry
        wr(3'd4, 2'd0, 64'h2000_0000, 1'b0);
        wr(3'd4, 2'd1, 64'h100, 1'b0);
        wr(3'd4, 2'd2, 64'h2, 1'b0);
        lookup(64'h2000_0080, 1'b1, 3'd4, 1'b0, 1'b1, 1'b0); tick();
        lookup(64'h2000_0100, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1); tick();

        // Region ending exactly at the top of the address space
        wr(3'd5, 2'd0, 64'hFFFF_FFFF_FFFF_F000, 1'b0);
        wr(3'd5, 2'd1, 64'h1000, 1'b0);
        wr(3'd5, 2'd2, 64'h1, 1'b0);
        lookup(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0); tick();
        lookup(64'hFFFF_FFFF_FFFF_EFFF, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1); tick();

        // Same-cycle write and lookup: lookup sees the old entry 0
        set_wr(3'd0, 2'd1, 64'h0);
        lookup(64'h8000_0000, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0); tick();
        chk("same_cycle_err", 64'(cfg_err_o), 64'd0);
        lookup(64'h8000_0000, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1); tick();

        // Async reset between edges while lookups stream
        lookup(64'h1_8000, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0); tick();
        lookup_valid = 1'b1;
        lookup_addr  = 64'h1_8000;
        #2;
        rst_ni = 1'b0;
        #1;
        chk("async_valid", 64'(lookup_valid_o), 64'd0);
        chk("async_hit",   64'(lookup_hit_o),   64'd0);
        chk("async_idx",   64'(lookup_idx_o),   64'd0);
        chk("async_exec",  64'(lookup_exec_o),  64'd0);
        lookup_valid = 1'b1;
        tick();
        chk("async_dropped", 64'(lookup_valid_o), 64'd0);
        rst_ni = 1'b1;
        wr(3'd2, 2'd0, 64'h5000, 1'b0);
        lookup(64'h8000_1000, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0); tick();
        lookup(64'h1_8000, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1); tick();
        tick();
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pma_region_table.md
Name: pma_region_table

Overview:
- Runtime-programmable physical-memory-attribute table for CVA6 cores.
- Successor to the fixed execute, cached and non-idempotent region rules in the core config package; those rule lists become one table of NrRegions entries.
- Each entry carries an attribute vector and a lock bit, and is reprogrammable through a CSR-style write port.
- Answers one pipelined lookup per cycle from the fetch and LSU side; result is registered, 1-cycle latency.

Parameters:
- NrRegions, 8, number of table entries (1..16).
- AddrWidth, 64, address width; matches the core AXI address width.
- RstBase, {8{64'h0}}, packed NrRegions*AddrWidth reset base values, entry 0 in the LSBs.
- RstLength, {8{64'h0}}, packed NrRegions*AddrWidth reset lengths; 0 means the entry is disabled.
- RstAttr, '0, packed NrRegions*3 reset attributes {nonidem, cached, exec}.
- RstLock, '0, NrRegions reset lock bits.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- lookup_valid_i  in  1  lookup request
- lookup_addr_i  in  AddrWidth  physical address to classify
- lookup_valid_o  out  1  result valid; registered copy of lookup_valid_i
- lookup_hit_o  out  1  some enabled entry matched
- lookup_idx_o  out  $clog2(NrRegions)  index of the matching entry
- lookup_exec_o  out  1  executable
- lookup_cached_o  out  1  cacheable
- lookup_nonidem_o  out  1  non-idempotent
- cfg_we_i  in  1  config write strobe
- cfg_idx_i  in  $clog2(NrRegions)  target entry
- cfg_field_i  in  2  0=base, 1=length, 2=attr+lock ({lock, nonidem, cached, exec} in wdata[3:0]), 3=reserved
- cfg_wdata_i  in  AddrWidth  write data
- cfg_err_o  out  1  one-cycle pulse: last write rejected

Behaviour:
- Reset (rst_ni low, asynchronous):
  - Entry i loads RstBase, RstLength, RstAttr and RstLock slices i.
  - All outputs 0; lookup_idx_o 0.
  - Reset asserted mid-lookup drops the request; no lookup_valid_o follows.
- Match rule:
  - Entry i matches when length_i != 0 and base_i <= addr < base_i + length_i.
  - The sum is computed at AddrWidth+1 bits, so a region ending at 2^AddrWidth is legal.
  - Ranges never wrap.
- Priority: lowest matching index wins. Overlaps are legal.
- Miss: lookup_hit_o=0, idx=0, exec=0, cached=0, nonidem=1. Unmapped space is treated as I/O.
- Latency:
  - Request sampled at edge N; result valid for the cycle after edge N.
  - No backpressure; one lookup accepted per cycle.
  - With lookup_valid_i low, lookup_valid_o=0 and the result fields hold their previous values.
- Config write, takes effect at the edge where cfg_we_i is sampled:
  - Locked entry: write ignored, cfg_err_o=1 next cycle.
  - field=3: write ignored, cfg_err_o=1 next cycle.
  - cfg_idx_i >= NrRegions: write ignored, cfg_err_o=1 next cycle.
  - Field 2 with wdata[3]=1 sets the lock. Lock is sticky until reset.
- Write and lookup in the same cycle: the lookup sees pre-write table contents. The next cycle's lookup sees the new contents.
- Back-to-back writes to the same entry apply in order, one per cycle.
- cfg_err_o is a single-cycle pulse per rejected write. Consecutive rejects keep it high.

Decomposition:
- Shared package (pma_pkg):
  - pma_attr_t struct {nonidem, cached, exec}.
  - pma_entry_t struct {base, length, attr, lock}.
  - Field encodings PMA_FIELD_BASE/LENGTH/ATTR.
  - Miss-default attribute constant.
- One sub-module, pma_range_match: combinational single-entry comparator, inputs base, length, addr; output match. Instantiated NrRegions times. The top level holds the table flops, the priority encoder, the output register and the config write logic.

Test Plan:
- Reset defaults: RstBase entry0=64'h8000_0000, RstLength=64'h4000_0000, RstAttr=3'b011; lookup 64'h8000_1000 -> next cycle valid=1, hit=1, idx=0, exec=1, cached=1, nonidem=0.
- Boundaries on that entry: 64'hBFFF_FFFF -> hit=1; 64'hC000_0000 -> hit=0, nonidem=1, exec=0, cached=0.
- Overlap priority: entry1 base 0x1_0000 len 0x1_0000 attr exec; entry3 base 0x0 len 0x10_0000 attr nonidem; lookup 0x1_8000 -> idx=1, exec=1, nonidem=0.
- Lock:
  - Write field 2 wdata 4'b1001 to entry 2, then field 0 wdata 0x5000 to entry 2 -> base unchanged, cfg_err_o=1 for exactly one cycle.
  - Writing idx=NrRegions -> cfg_err_o=1.
- Same-cycle write and lookup: set entry 0 length 0 while looking up 0x8000_0000 -> that result hit=1; the next-cycle lookup of the same address -> hit=0.
- Async reset mid-stream: drive lookups every cycle, pull rst_ni low between edges -> outputs 0 immediately; locks cleared; table back to the reset values.
